fpu_mul_arbiter: RTL and testbench
==================================

// Module: fpu_mul_arbiter
// PURPOSE
//  Shares one FP32 multiplier controller (Mul_cntrl) between NUM_REQ requesters. Round-robin arbitration, one op in flight.
//  Sits between the issue ports of the FPU front-end and the multiplier controller.
//  Registers the winner's operands, pulses Data_valid, waits for Dataout_valid, and returns result/Exc to the winner only.
// PARAMETERS
//  NUM_REQ     4     number of requesters (2..8)
//  TIMEOUT     255   watchdog limit in cycles; used only with FPU_ARB_TIMEOUT_EN
// PORTS
//  CLK               in   1          clock, rising edge
//  RSTn              in   1          reset, asynchronous, active-low
//  Req               in   NUM_REQ    per-requester request level
//  Req_Datain1       in   NUM_REQ*32 operand 1, slice i = [32*i+31:32*i]
//  Req_Datain2       in   NUM_REQ*32 operand 2, same slicing
//  Req_Mode          in   NUM_REQ*3  rounding mode, slice i = [3*i+2:3*i]
//  Rsp_valid         out  NUM_REQ    one-hot, 1-cycle result pulse to the served requester
//  Rsp_Dataout       out  32         result, valid when any Rsp_valid bit is set
//  Rsp_Exc           out  3          exception code with the result
//  Busy              out  1          high in every state except ARB_IDLE
//  Mul_Datain1       out  32         to controller Datain1
//  Mul_Datain2       out  32         to controller Datain2
//  Mul_Mode          out  3          to controller Mode
//  Mul_Data_valid    out  1          to controller Data_valid, 1-cycle pulse
//  Mul_Dataout       in   32         from controller Dataout
//  Mul_Dataout_valid in   1          from controller Dataout_valid
//  Mul_Exc           in   3          from controller Exc
// BEHAVIOUR
//  Reset (RSTn=0, async): state=ARB_IDLE, rr_ptr=0, grant=0. All outputs 0: Rsp_*, Busy, Mul_* (Mul_Data_valid included).
//  Reset mid-operation aborts the op and drops its result. The controller shares RSTn and resets with this block.
//  FSM, registered state, all outputs registered:
//   ARB_IDLE:    if |Req, pick the first set bit at or after rr_ptr (wrapping), then
//                latch grant, Datain1/2 and Mode into the Mul_* registers, go to ARB_ISSUE. Otherwise stay.
//   ARB_ISSUE:   Mul_Data_valid=1 for exactly this cycle; go to ARB_WAIT.
//   ARB_WAIT:    on Mul_Dataout_valid, latch Mul_Dataout->Rsp_Dataout and Mul_Exc->Rsp_Exc, go to ARB_RESPOND.
//   ARB_RESPOND: Rsp_valid[grant]=1 for one cycle; rr_ptr=(grant+1) mod NUM_REQ; go to ARB_IDLE.
//  Latency: Req seen at edge 0 -> Mul_Data_valid high in cycle 1 -> Rsp_valid one cycle after Mul_Dataout_valid.
//  Requester protocol:
//   - Hold Req and operands stable until Rsp_valid; deassert Req on the cycle Rsp_valid is seen.
//   - Req dropped before grant = withdrawn, no response.
//   - Req dropped after grant is ignored: the op completes and Rsp_valid still pulses.
//  Fairness: a requester that holds Req after its response ranks last, so each requester waits at most NUM_REQ-1 ops.
//  Simultaneous events: new Req in ARB_WAIT/ARB_RESPOND waits for ARB_IDLE (min 1 idle cycle between ops).
//   Mul_Dataout_valid outside ARB_WAIT is ignored.
//  Mul_Datain1/2 and Mul_Mode hold their values until the next grant; they are not cleared.
//  rr_ptr is $clog2(NUM_REQ) bits and wraps from NUM_REQ-1 to 0.
// CONFIGURATION
//  FPU_ARB_TIMEOUT_EN defined:
//   - An 8..16-bit counter clears on entry to ARB_WAIT and increments each cycle in ARB_WAIT.
//   - When it reaches TIMEOUT with no Mul_Dataout_valid: go to ARB_RESPOND with Rsp_Dataout=32'h7FC00000 and Rsp_Exc=EXC_TIMEOUT(3'b111).
//   - If Mul_Dataout_valid arrives in the same cycle as the timeout, the real result wins.
//  FPU_ARB_TIMEOUT_EN undefined: no counter; ARB_WAIT waits indefinitely.
// STRUCTURE
//  Package fpu_arb_pkg: typedef enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESPOND} fpu_arb_state;
//   localparam EXC_TIMEOUT=3'b111; localparam QNAN32=32'h7FC00000.
//  Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs index and found. Also reused by future adder/divider arbiters.
//  The top holds the FSM, operand/result registers, rr_ptr and the optional watchdog.
// TESTING
//  Single op: Req=4'b0001, operands 3F800000 x 40000000; model returns 40000000 after 6 cycles
//   -> one Mul_Data_valid pulse, Rsp_valid=0001, Rsp_Dataout=40000000, Rsp_Exc=0.
//  Contention: Req=1111 held, 8 ops -> grant order 0,1,2,3,0,1,2,3; exactly one Rsp_valid bit per response.
//  Withdraw/late drop: req2 drops Req before grant -> never served.
//   req1 drops Req in ARB_WAIT -> Rsp_valid=0010 still pulses once.
//  Exception pass-through: model returns Exc=3'b010 with 7F800000 -> Rsp_Exc=010, Rsp_Dataout=7F800000.
//   A spurious Mul_Dataout_valid while idle -> no Rsp_valid.
//  Async reset: assert RSTn=0 mid ARB_WAIT, off-edge -> all outputs 0 immediately, rr_ptr=0, no stale Rsp_valid after release.
//  Watchdog (FPU_ARB_TIMEOUT_EN, TIMEOUT=20): model never answers -> Rsp_valid after 20 ARB_WAIT cycles, Rsp_Exc=111, Rsp_Dataout=7FC00000.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU functional-unit arbiters.
// FPU_ARB_TIMEOUT_EN selects the watchdog result constants used by the multiplier arbiter.
package fpu_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT    = 2'd2,
        ARB_RESPOND = 2'd3
    } fpu_arb_state;

    localparam logic [2:0]  EXC_TIMEOUT = 3'b111;
    localparam logic [31:0] QNAN32      = 32'h7FC0_0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Shared by the multiplier arbiter and the planned adder/divider arbiters.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [PW-1:0] cand [N];
    logic [N-1:0]  hit;

    // cand[k] is the requester k places after ptr; ptr is always below N
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum       = {1'b0, ptr} + (PW+1)'(gi);
            assign cand[gi]  = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx   = cand[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier controller between NUM_REQ issue ports.
// Define FPU_ARB_TIMEOUT_EN to add a watchdog that answers with a quiet NaN after TIMEOUT wait cycles.
module fpu_mul_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic [NUM_REQ-1:0]     Req,
    input  logic [NUM_REQ*32-1:0]  Req_Datain1,
    input  logic [NUM_REQ*32-1:0]  Req_Datain2,
    input  logic [NUM_REQ*3-1:0]   Req_Mode,
    output logic [NUM_REQ-1:0]     Rsp_valid,
    output logic [31:0]            Rsp_Dataout,
    output logic [2:0]             Rsp_Exc,
    output logic                   Busy,
    output logic [31:0]            Mul_Datain1,
    output logic [31:0]            Mul_Datain2,
    output logic [2:0]             Mul_Mode,
    output logic                   Mul_Data_valid,
    input  logic [31:0]            Mul_Dataout,
    input  logic                   Mul_Dataout_valid,
    input  logic [2:0]             Mul_Exc
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = 16;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
            $error("fpu_mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT 1..65535");
        end
    endgenerate

    logic [31:0] op1 [NUM_REQ];
    logic [31:0] op2 [NUM_REQ];
    logic [2:0]  mode [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op1[gi]  = Req_Datain1[32*gi +: 32];
            assign op2[gi]  = Req_Datain2[32*gi +: 32];
            assign mode[gi] = Req_Mode[3*gi +: 3];
        end
    endgenerate

    fpu_arb_state        state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [31:0]         mul_d1_q, mul_d1_d;
    logic [31:0]         mul_d2_q, mul_d2_d;
    logic [2:0]          mul_mode_q, mul_mode_d;
    logic                mul_dv_q, mul_dv_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic [2:0]          rsp_exc_q, rsp_exc_d;
    logic                busy_q, busy_d;
`ifdef FPU_ARB_TIMEOUT_EN
    logic [TW-1:0]       wd_cnt_q, wd_cnt_d;
`endif

    logic [PW-1:0] pick_idx;
    logic          pick_found;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req   (Req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        mul_d1_d    = mul_d1_q;
        mul_d2_d    = mul_d2_q;
        mul_mode_d  = mul_mode_q;
        mul_dv_d    = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_exc_d   = rsp_exc_q;
`ifdef FPU_ARB_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    mul_d1_d   = op1[pick_idx];
                    mul_d2_d   = op2[pick_idx];
                    mul_mode_d = mode[pick_idx];
                    mul_dv_d   = 1'b1;
                    state_d    = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            ARB_WAIT: begin
                // A real result arriving on the timeout cycle takes priority
                if (Mul_Dataout_valid) begin
                    rsp_data_d  = Mul_Dataout;
                    rsp_exc_d   = Mul_Exc;
                    rsp_valid_d = NUM_REQ'(1) << grant_q;
                    state_d     = ARB_RESPOND;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (wd_cnt_q == TW'(TIMEOUT - 1)) begin
                    rsp_data_d  = QNAN32;
                    rsp_exc_d   = EXC_TIMEOUT;
                    rsp_valid_d = NUM_REQ'(1) << grant_q;
                    state_d     = ARB_RESPOND;
                end else begin
                    wd_cnt_d = wd_cnt_q + TW'(1);
                end
`endif
            end
            ARB_RESPOND: begin
                // The just-served port ranks last in the next arbitration
                rr_ptr_d = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + PW'(1);
                state_d  = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            mul_d1_q    <= '0;
            mul_d2_q    <= '0;
            mul_mode_q  <= '0;
            mul_dv_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_exc_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            mul_d1_q    <= mul_d1_d;
            mul_d2_q    <= mul_d2_d;
            mul_mode_q  <= mul_mode_d;
            mul_dv_q    <= mul_dv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_exc_q   <= rsp_exc_d;
            busy_q      <= busy_d;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign Rsp_valid      = rsp_valid_q;
    assign Rsp_Dataout    = rsp_data_q;
    assign Rsp_Exc        = rsp_exc_q;
    assign Busy           = busy_q;
    assign Mul_Datain1    = mul_d1_q;
    assign Mul_Datain2    = mul_d2_q;
    assign Mul_Mode       = mul_mode_q;
    assign Mul_Data_valid = mul_dv_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter: vector table plus hand-written reset, spurious-valid and watchdog sequences.
module tb_fpu_mul_arbiter;
    import fpu_arb_pkg::*;

    localparam int N = 4;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic [N-1:0]     Req = '0;
    logic [N*32-1:0]  Req_Datain1 = '0;
    logic [N*32-1:0]  Req_Datain2 = '0;
    logic [N*3-1:0]   Req_Mode = '0;
    logic [N-1:0]     Rsp_valid;
    logic [31:0]      Rsp_Dataout;
    logic [2:0]       Rsp_Exc;
    logic             Busy;
    logic [31:0]      Mul_Datain1;
    logic [31:0]      Mul_Datain2;
    logic [2:0]       Mul_Mode;
    logic             Mul_Data_valid;
    logic [31:0]      Mul_Dataout = '0;
    logic             Mul_Dataout_valid = 1'b0;
    logic [2:0]       Mul_Exc = '0;

    always #5 CLK = ~CLK;

    fpu_mul_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (20)
    ) dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .Req               (Req),
        .Req_Datain1       (Req_Datain1),
        .Req_Datain2       (Req_Datain2),
        .Req_Mode          (Req_Mode),
        .Rsp_valid         (Rsp_valid),
        .Rsp_Dataout       (Rsp_Dataout),
        .Rsp_Exc           (Rsp_Exc),
        .Busy              (Busy),
        .Mul_Datain1       (Mul_Datain1),
        .Mul_Datain2       (Mul_Datain2),
        .Mul_Mode          (Mul_Mode),
        .Mul_Data_valid    (Mul_Data_valid),
        .Mul_Dataout       (Mul_Dataout),
        .Mul_Dataout_valid (Mul_Dataout_valid),
        .Mul_Exc           (Mul_Exc)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] late_drop;
        bit           hold;
        int           g;
        logic [31:0]  res;
        logic [2:0]   exc;
        int           lat;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] a_op [N];
    logic [31:0] b_op [N];
    logic [2:0]  m_op [N];
    vec_t        vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_issue(output bit ok);
        int t = 0;
        while (Mul_Data_valid !== 1'b1 && t < 40) begin
            @(negedge CLK);
            t++;
        end
        ok = (Mul_Data_valid === 1'b1);
        chk("issue_seen", {31'd0, Mul_Data_valid}, 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        bit ok;
        logic [N-1:0] exp_oh;
        exp_oh = N'(1) << v.g;
        wait_issue(ok);
        if (!ok) return;
        chk("busy_issue", {31'd0, Busy}, 32'd1);
        chk("mul_a", Mul_Datain1, a_op[v.g]);
        chk("mul_b", Mul_Datain2, b_op[v.g]);
        chk("mul_mode", {29'd0, Mul_Mode}, {29'd0, m_op[v.g]});
        @(negedge CLK);
        chk("dv_pulse", {31'd0, Mul_Data_valid}, 32'd0);
        Req = Req & ~v.late_drop;
        for (int i = 1; i < v.lat; i++) @(negedge CLK);
        chk("no_early_rsp", {28'd0, Rsp_valid}, 32'd0);
        Mul_Dataout       = v.res;
        Mul_Exc           = v.exc;
        Mul_Dataout_valid = 1'b1;
        @(negedge CLK);
        Mul_Dataout_valid = 1'b0;
        chk("rsp_valid", {28'd0, Rsp_valid}, {28'd0, exp_oh});
        chk("rsp_data", Rsp_Dataout, v.res);
        chk("rsp_exc", {29'd0, Rsp_Exc}, {29'd0, v.exc});
        if (!v.hold) Req = '0;
        @(negedge CLK);
        chk("rsp_one_cycle", {28'd0, Rsp_valid}, 32'd0);
        $display("[TB] op grant=%0d res=%h exc=%0d", v.g, v.res, v.exc);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   ok;
        int   cyc;

        for (int i = 0; i < N; i++) begin
            a_op[i] = 32'h3F80_0000 + (i << 20);
            b_op[i] = 32'h4000_0000 + i;
            m_op[i] = 3'(i + 1);
            Req_Datain1[32*i +: 32] = a_op[i];
            Req_Datain2[32*i +: 32] = b_op[i];
            Req_Mode[3*i +: 3]      = m_op[i];
        end

        // Contention with all ports held, then single op, exception, withdraw/late drop, wraps
        for (int k = 0; k < 8; k++)
            vt[k] = '{req: 4'b1111, late_drop: 4'b0000, hold: (k != 7), g: k % 4,
                      res: 32'h4100_0000 + k, exc: 3'b000, lat: 1 + (k % 4)};
        vt[8]  = '{req: 4'b0001, late_drop: 4'b0000, hold: 0, g: 0, res: 32'h4000_0000, exc: 3'b000, lat: 6};
        vt[9]  = '{req: 4'b1000, late_drop: 4'b0000, hold: 0, g: 3, res: 32'h7F80_0000, exc: 3'b010, lat: 3};
        vt[10] = '{req: 4'b0110, late_drop: 4'b0110, hold: 0, g: 1, res: 32'h3F00_0000, exc: 3'b001, lat: 4};
        vt[11] = '{req: 4'b1100, late_drop: 4'b0000, hold: 0, g: 2, res: 32'h4280_0000, exc: 3'b000, lat: 2};
        vt[12] = '{req: 4'b0011, late_drop: 4'b0000, hold: 0, g: 0, res: 32'hC080_0000, exc: 3'b100, lat: 1};

        @(negedge CLK);
        @(negedge CLK);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_rsp_valid", {28'd0, Rsp_valid}, 32'd0);
        chk("rst_mul_dv", {31'd0, Mul_Data_valid}, 32'd0);
        chk("rst_rsp_data", Rsp_Dataout, 32'd0);
        chk("rst_mul_a", Mul_Datain1, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        for (int k = 0; k < 13; k++) begin
            Req = vt[k].req;
            run_op(vt[k]);
        end

        // Withdrawn req2 must never be granted
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("withdraw_idle_dv", {31'd0, Mul_Data_valid}, 32'd0);
        end
        chk("withdraw_idle_busy", {31'd0, Busy}, 32'd0);

        // Spurious result while idle
        Mul_Dataout = 32'h1234_5678;
        Mul_Dataout_valid = 1'b1;
        @(negedge CLK);
        Mul_Dataout_valid = 1'b0;
        chk("spurious_rsp", {28'd0, Rsp_valid}, 32'd0);
        @(negedge CLK);
        chk("spurious_rsp2", {28'd0, Rsp_valid}, 32'd0);
        chk("spurious_busy", {31'd0, Busy}, 32'd0);
        $display("[TB] spurious result while idle ignored");

        // Async reset mid-wait; rr_ptr is 1 here, so 1001 after reset tells 0 from 1
        Req = 4'b0100;
        wait_issue(ok);
        chk("rst_op_mul_a", Mul_Datain1, a_op[2]);
        Req = '0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RSTn = 1'b0;
        #1;
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_mul_a", Mul_Datain1, 32'd0);
        chk("arst_mul_b", Mul_Datain2, 32'd0);
        chk("arst_mul_mode", {29'd0, Mul_Mode}, 32'd0);
        chk("arst_rsp_data", Rsp_Dataout, 32'd0);
        chk("arst_rsp_exc", {29'd0, Rsp_Exc}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        Mul_Dataout = 32'h4000_0000;
        Mul_Dataout_valid = 1'b1;
        @(negedge CLK);
        Mul_Dataout_valid = 1'b0;
        chk("arst_no_stale", {28'd0, Rsp_valid}, 32'd0);
        @(negedge CLK);
        chk("arst_no_stale2", {28'd0, Rsp_valid}, 32'd0);
        $display("[TB] async reset mid-wait");
        v = '{req: 4'b1001, late_drop: 4'b0000, hold: 0, g: 0, res: 32'h4040_0000, exc: 3'b000, lat: 2};
        Req = v.req;
        run_op(v);

`ifdef FPU_ARB_TIMEOUT_EN
        Req = 4'b0001;
        wait_issue(ok);
        cyc = 0;
        while (Rsp_valid === '0 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        Req = '0;
        chk("wd_cycles", 32'(cyc), 32'd21);
        chk("wd_rsp_valid", {28'd0, Rsp_valid}, 32'd1);
        chk("wd_rsp_data", Rsp_Dataout, QNAN32);
        chk("wd_rsp_exc", {29'd0, Rsp_Exc}, {29'd0, EXC_TIMEOUT});
        @(negedge CLK);
        $display("[TB] watchdog response after %0d cycles", cyc);
`else
        cyc = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
